sub_bytes_iter: RTL and testbench

//  Multi-cycle AES SubBytes engine: applies the S-box to a 128-bit state using LANES S-box instances per cycle.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/sbox_lane.sv | 18 +
 rtl/sub_bytes_iter.sv | 131 +++++++++++++
 tb/tb_sub_bytes_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) S-box functions for the iterative SubBytes engine.
package aes_pkg;

    localparam int unsigned AES_NB_BYTES = 16;
    localparam int unsigned AES_STATE_W  = 128;

    typedef logic [7:0] byte_t;
    typedef byte_t [AES_NB_BYTES-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift-and-add with xtime).
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t r;
        byte_t sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic byte_t rotl8(input byte_t b, input int unsigned n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    function automatic byte_t sbox_fwd(input byte_t b);
        byte_t i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic byte_t sbox_inv(input byte_t s);
        byte_t b;
        b = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One-byte S-box lane; with SUBBYTES_INV_EN defined it also carries the inverse S-box and a mode mux.
module sbox_lane
    import aes_pkg::*;
(
    input  byte_t data,
`ifdef SUBBYTES_INV_EN
    input  logic  inv,
`endif
    output byte_t sub_c
);

`ifdef SUBBYTES_INV_EN
    assign sub_c = inv ? sbox_inv(data) : sbox_fwd(data);
`else
    assign sub_c = sbox_fwd(data);
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Multi-cycle AES SubBytes: LANES S-box lanes rewrite the state register in place over 16/LANES beats.
// Optional feature macro: SUBBYTES_INV_EN adds the inv_mode port and inverse S-box lanes.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t state_in,
`ifdef SUBBYTES_INV_EN
    input  logic   inv_mode,
`endif
    output logic   out_valid,
    input  logic   out_ready,
    output state_t state_out,
    output logic   busy
);

    localparam int unsigned N  = AES_NB_BYTES / LANES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_t          fsm_q;
    fsm_t          fsm_d;
    logic [CW-1:0] cnt_q;
    state_t        st_q;
    logic          accept;
    logic          last_beat;
    logic [3:0]    lane_idx [LANES];
    byte_t         lane_in  [LANES];
    byte_t         lane_out [LANES];
`ifdef SUBBYTES_INV_EN
    logic          inv_q;
`endif

    // Lane g works on byte LANES*cnt+g of the state register.
    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        assign lane_idx[g] = 4'(32'(cnt_q) * LANES + 32'(g));
        assign lane_in[g]  = st_q[lane_idx[g]];

        sbox_lane u_lane (
            .data  (lane_in[g]),
`ifdef SUBBYTES_INV_EN
            .inv   (inv_q),
`endif
            .sub_c (lane_out[g])
        );
    end

    // Next-state logic.
    always_comb begin
        fsm_d     = fsm_q;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(N - 1)) begin
                    last_beat = 1'b1;
                    fsm_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register and registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            in_ready  <= (fsm_d == IDLE);
            out_valid <= (fsm_d == DONE);
            busy      <= (fsm_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (fsm_q == RUN) begin
            cnt_q <= last_beat ? '0 : cnt_q + CW'(1);
        end
    end

    // Datapath: capture on accept, then in-place substitution one beat at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
        end else if (accept) begin
            st_q <= state_in;
        end else if (fsm_q == RUN) begin
            for (int l = 0; l < int'(LANES); l++) begin
                st_q[lane_idx[l]] <= lane_out[l];
            end
        end
    end

`ifdef SUBBYTES_INV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= inv_mode;
        end
    end
`endif

    assign state_out = st_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: five instances (LANES=1,2,4,8,16) checked against a table model built
// from GF(2^8) arithmetic; covers SUBBYTES_INV_EN when that macro is defined.
module tb_sub_bytes_iter;

    localparam int ND   = 5;
    localparam int MAIN = 2;
    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic         clk;
    logic         rst_n;
    logic [127:0] si;
    logic         iv   [ND];
    logic         ordy [ND];
    logic         irdy [ND];
    logic         ov   [ND];
    logic         bsy  [ND];
    logic [127:0] so   [ND];
`ifdef SUBBYTES_INV_EN
    logic         inv;
`endif

    bit           mode;
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    int           n_cmp;
    int           n_bad;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (irdy[g]),
            .state_in  (si),
`ifdef SUBBYTES_INV_EN
            .inv_mode  (inv),
`endif
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .state_out (so[g]),
            .busy      (bsy[g])
        );
    end

    always #5 clk = ~clk;

    // Carry-less polynomial product reduced modulo 0x11b.
    function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic void build_tables();
        logic [7:0] c;
        logic [7:0] y;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int t = 1; t < 256; t++) if (pmul(8'(x), 8'(t)) == 8'h01) y = 8'(t);
            for (int i = 0; i < 8; i++)
                s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endfunction

    function automatic logic [127:0] model(input logic [127:0] v, input bit m);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = m ? isb[v[8*k +: 8]] : sb[v[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input int d, input logic [127:0] v);
        int guard;
        guard = 0;
`ifdef SUBBYTES_INV_EN
        inv = mode;
`endif
        si    = v;
        iv[d] = 1'b1;
        while (!irdy[d] && guard < 40) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!ov[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic finish_out(input int d, input string tag);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        check({tag, "_idle"}, 128'({ov[d], irdy[d], bsy[d]}), 128'(3'b010));
    endtask

    task automatic run(input int d, input logic [127:0] v, input logic [127:0] exp, input string tag);
        int lat;
        start(d, v);
        wait_done(d, lat);
        check({tag, "_lat"}, 128'(lat), 128'(16 >> d));
        check({tag, "_out"}, so[d], exp);
        finish_out(d, tag);
    endtask

    initial begin
        int           lat;
        logic [127:0] v;
        logic [127:0] v2;
        logic [127:0] exp;

        clk   = 1'b0;
        rst_n = 1'b0;
        si    = '0;
        mode  = 1'b0;
        n_cmp = 0;
        n_bad = 0;
`ifdef SUBBYTES_INV_EN
        inv = 1'b0;
`endif
        for (int i = 0; i < ND; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        build_tables();

        // Reset values.
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_flags", 128'({ov[MAIN], irdy[MAIN], bsy[MAIN]}), 128'(3'b010));
        check("rst_state", so[MAIN], '0);

        // out_ready high while idle must not produce a result.
        ordy[MAIN] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_ordy", 128'({ov[MAIN], bsy[MAIN]}), 128'(2'b00));
        end
        ordy[MAIN] = 1'b0;

        // Known-answer vector on the default configuration.
        run(MAIN, FIPS_IN, FIPS_OUT, "fips");
        check("fips_model", model(FIPS_IN, 1'b0), so[MAIN]);

        // Latency sweep across all lane counts, known answer plus random states.
        for (int d = 0; d < ND; d++) begin
            run(d, FIPS_IN, FIPS_OUT, $sformatf("sweep%0d_fips", d));
            for (int r = 0; r < 3; r++) begin
                v = rnd128();
                run(d, v, model(v, 1'b0), $sformatf("sweep%0d_rnd%0d", d, r));
            end
        end

        // Backpressure: result held while out_ready is low; input pulses ignored.
        v   = rnd128();
        exp = model(v, 1'b0);
        start(MAIN, v);
        wait_done(MAIN, lat);
        check("bp_lat", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            iv[MAIN] = i[0];
            si       = rnd128();
            @(posedge clk); #1;
            check("bp_flags", 128'({ov[MAIN], irdy[MAIN], bsy[MAIN]}), 128'(3'b101));
            check("bp_state", so[MAIN], exp);
        end
        iv[MAIN] = 1'b0;
        finish_out(MAIN, "bp");

        // Back-to-back with in_valid held high and out_ready high.
        v  = rnd128();
        v2 = rnd128();
        si         = v;
        iv[MAIN]   = 1'b1;
        ordy[MAIN] = 1'b1;
        @(posedge clk); #1;
        check("b2b_acc1", 128'({irdy[MAIN], bsy[MAIN]}), 128'(2'b01));
        si = v2;
        wait_done(MAIN, lat);
        check("b2b_lat1", 128'(lat), 128'(4));
        check("b2b_out1", so[MAIN], model(v, 1'b0));
        @(posedge clk); #1;
        check("b2b_hs", 128'({ov[MAIN], irdy[MAIN]}), 128'(2'b01));
        @(posedge clk); #1;
        check("b2b_acc2", 128'({irdy[MAIN], bsy[MAIN]}), 128'(2'b01));
        iv[MAIN] = 1'b0;
        wait_done(MAIN, lat);
        check("b2b_lat2", 128'(lat), 128'(4));
        check("b2b_out2", so[MAIN], model(v2, 1'b0));
        @(posedge clk); #1;
        ordy[MAIN] = 1'b0;
        check("b2b_end", 128'({ov[MAIN], irdy[MAIN]}), 128'(2'b01));

        // Reset in the middle of RUN, then a fresh vector.
        start(MAIN, rnd128());
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 128'({ov[MAIN], irdy[MAIN], bsy[MAIN]}), 128'(3'b001));
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", 128'({ov[MAIN], irdy[MAIN], bsy[MAIN]}), 128'(3'b010));
        check("mid_rst_state", so[MAIN], '0);
        #2 rst_n = 1'b1;
        v = rnd128();
        run(MAIN, v, model(v, 1'b0), "post_rst");

`ifdef SUBBYTES_INV_EN
        // Inverse mode, known answer and random round trip on every lane count.
        mode = 1'b1;
        run(MAIN, FIPS_OUT, FIPS_IN, "inv_fips");
        for (int d = 0; d < ND; d++) begin
            v = rnd128();
            run(d, v, model(v, 1'b1), $sformatf("inv%0d_rnd", d));
        end
        mode = 1'b0;
        v = rnd128();
        run(MAIN, v, model(v, 1'b0), "inv_back_fwd");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
